// File: rtl/sig_chk_pkg.sv
// Shared definitions for the MISR signature checker.
//   state_e        checker FSM states
//   MAX_WIDTH      widest signature the shared update function handles
//   DEFAULT_*      default golden signature and upstream CRC stimulus seed
//   misr_taps/misr_keep/misr_next
//                  width-generic MISR step, also used by the stimulus generator
package sig_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_ACCUM,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int          MAX_WIDTH        = 64;
    localparam logic [63:0] DEFAULT_EXPECTED = 64'hb6d6b86aa20a882a;
    localparam logic [63:0] CRC_SEED         = 64'h5aef0c8d_d70a4497;

    // Feedback taps: msb, bit 2 and bit 0 of the current signature.
    function automatic logic [MAX_WIDTH-1:0] misr_taps(input int width);
        return (64'd1 << (width - 1)) | 64'd5;
    endfunction

    // Mask of the bits that belong to a signature of the given width.
    function automatic logic [MAX_WIDTH-1:0] misr_keep(input int width);
        return (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    // One MISR step: shift left, feed back the tap parity into bit 0, fold in the sample.
    function automatic logic [MAX_WIDTH-1:0] misr_next(
        input logic [MAX_WIDTH-1:0] sig,
        input logic [MAX_WIDTH-1:0] din,
        input logic [MAX_WIDTH-1:0] taps,
        input logic [MAX_WIDTH-1:0] keep
    );
        logic fb;
        fb = ^(sig & taps);
        return (((sig << 1) | {{(MAX_WIDTH-1){1'b0}}, fb}) ^ din) & keep;
    endfunction

endpackage

// File: rtl/sig_misr_checker_if.sv
// Result-stream interface between the stage under test and the checker.
//   in_valid   producer -> checker   in_result carries a sample this cycle
//   in_ready   checker  -> producer  checker can take a sample this cycle
//   in_result  producer -> checker   WIDTH-bit result vector
// Handshake: a sample transfers on a rising clk edge exactly when in_valid and
// in_ready are both high; with either low nothing transfers and nothing changes.
interface sig_misr_checker_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;

    modport master (output in_valid, output in_result, input in_ready);
    modport slave  (input in_valid, input in_result, output in_ready);
endinterface

// File: rtl/sig_misr.sv
// WIDTH-bit multiple-input signature register.
//   clk, rst_n  clock, synchronous active-low reset (clears the signature)
//   clr         clear the signature to 0 (wins over en)
//   en          fold din into the signature this cycle
//   din         sample to fold in
//   sig         current signature
module sig_misr
    import sig_chk_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);
    localparam logic [MAX_WIDTH-1:0] TAPS = misr_taps(WIDTH);
    localparam logic [MAX_WIDTH-1:0] KEEP = misr_keep(WIDTH);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_next;

    assign sig_next = WIDTH'(misr_next(MAX_WIDTH'(sig_q), MAX_WIDTH'(din), TAPS, KEEP));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_next;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/sig_misr_checker.sv
// Signature checker for a per-cycle result stream.
// Discards the first WARMUP accepted samples, folds the rest into a MISR up to
// NUM_SAMPLES total, then compares against EXPECTED and raises sticky flags.
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle pulse: clear everything and begin a run (any state)
//   in_if        result stream (slave side)
//   busy         run in progress (warm-up, accumulate or compare)
//   done         sticky: compare finished
//   pass, fail   sticky: compare result, both 0 until done
//   signature    current MISR value
//   sample_cnt   samples accepted in this run
//   dbg_state    FSM state
module sig_misr_checker
    import sig_chk_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          WARMUP      = 10,
    parameter int          NUM_SAMPLES = 99,
    parameter logic [63:0] EXPECTED    = DEFAULT_EXPECTED,
    localparam int         CW          = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    sig_misr_checker_if.slave   in_if,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [WIDTH-1:0]    signature,
    output logic [CW-1:0]       sample_cnt,
    output state_e              dbg_state
);
    if (WARMUP >= NUM_SAMPLES || WIDTH < 3 || WIDTH > MAX_WIDTH) begin : g_bad_params
        $error("sig_misr_checker: need WARMUP < NUM_SAMPLES and 3 <= WIDTH <= 64");
    end

    localparam logic [CW-1:0]    WARMUP_CNT = CW'(WARMUP);
    localparam logic [CW-1:0]    LAST_CNT   = CW'(NUM_SAMPLES);
    localparam logic [WIDTH-1:0] GOLD       = EXPECTED[WIDTH-1:0];

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          misr_clr, misr_en;
    logic          ready;
    logic          accept;
    logic [WIDTH-1:0] sig;

    // A start pulse takes priority over the stream, so ready drops for that
    // cycle and an offered sample simply waits.
    assign ready   = (state_q == S_WARMUP || state_q == S_ACCUM) && !start;
    assign accept  = in_if.in_valid && ready;
    assign cnt_inc = cnt_q + CW'(1);

    sig_misr #(.WIDTH(WIDTH)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (in_if.in_result),
        .sig   (sig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        if (start) begin
            state_d  = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
            cnt_d    = '0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            misr_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_WARMUP: begin
                    if (accept) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == WARMUP_CNT) state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        cnt_d   = cnt_inc;
                        misr_en = 1'b1;
                        if (cnt_inc == LAST_CNT) state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    done_d  = 1'b1;
                    pass_d  = (sig == GOLD);
                    fail_d  = (sig != GOLD);
                    state_d = S_DONE;
                end
                default: begin
                    // IDLE and DONE wait for start with everything held.
                end
            endcase
        end
    end

    assign in_if.in_ready = ready;
    assign busy       = (state_q == S_WARMUP) || (state_q == S_ACCUM) || (state_q == S_CHECK);
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign signature  = sig;
    assign sample_cnt = cnt_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sig_misr_checker.sv
module tb_sig_misr_checker;
    import sig_chk_pkg::*;

    // ---------------- reference helpers ----------------
    function automatic logic [63:0] xs_next(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Signature step straight from the rule: shift in parity of msb, bit2, bit0, xor sample.
    function automatic logic [63:0] ref_step(input logic [63:0] s, input logic [63:0] x, input int w);
        logic [63:0] mask, t;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        t = (s >> (w - 1)) ^ (s >> 2) ^ s;
        return (((s << 1) | {63'd0, t[0]}) ^ x) & mask;
    endfunction

    function automatic logic [63:0] calc_gold();
        logic [63:0] x, s;
        x = CRC_SEED;
        s = 64'd0;
        for (int i = 0; i < 99; i++) begin
            x = xs_next(x);
            if (i >= 10) s = ref_step(s, x, 64);
        end
        return s;
    endfunction

    localparam logic [63:0] GOLD_B = calc_gold();

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b;
    logic [7:0]  sig_a;
    logic [63:0] sig_b;
    logic [2:0]  cnt_a;
    logic [6:0]  cnt_b;
    state_e      st_a, st_b;

    sig_misr_checker_if #(.WIDTH(8))  if_a ();
    sig_misr_checker_if #(.WIDTH(64)) if_b ();

    sig_misr_checker #(.WIDTH(8), .WARMUP(2), .NUM_SAMPLES(5), .EXPECTED(64'd7)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_if(if_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
        .signature(sig_a), .sample_cnt(cnt_a), .dbg_state(st_a)
    );

    sig_misr_checker #(.EXPECTED(GOLD_B)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_if(if_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .signature(sig_b), .sample_cnt(cnt_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is "active" while samples are still wanted,
    // then one compare cycle, then the flags.
    typedef struct {
        logic        active;
        logic        check;
        logic        done;
        logic        pass;
        logic        fail;
        int          cnt;
        logic [63:0] sig;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_step(input model_t m, input logic rst_i, input logic start_i,
                                          input logic valid_i, input logic [63:0] data,
                                          input int w, input int warm, input int num,
                                          input logic [63:0] gold);
        model_t r;
        r = m;
        if (!rst_i || start_i) begin
            r.active = start_i && rst_i;
            r.check  = 1'b0;
            r.done   = 1'b0;
            r.pass   = 1'b0;
            r.fail   = 1'b0;
            r.cnt    = 0;
            r.sig    = 64'd0;
        end else if (m.active && valid_i) begin
            r.cnt = m.cnt + 1;
            if (r.cnt > warm) r.sig = ref_step(m.sig, data, w);
            if (r.cnt == num) begin
                r.active = 1'b0;
                r.check  = 1'b1;
            end
        end else if (m.check) begin
            r.check = 1'b0;
            r.done  = 1'b1;
            r.pass  = (m.sig == gold);
            r.fail  = (m.sig != gold);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_a = model_step(m_a, rst_n, start_a, if_a.in_valid, 64'(if_a.in_result), 8, 2, 5, 64'd7);
        m_b = model_step(m_b, rst_n, start_b, if_b.in_valid, if_b.in_result, 64, 10, 99, GOLD_B);
    end

    task automatic cmp_model(input string tag, input model_t m, input logic start_i,
                             input logic busy, input logic ready, input logic done,
                             input logic pass, input logic fail, input logic [63:0] sig,
                             input int cnt);
        check({tag, "_busy"},  64'(busy),  64'(m.active || m.check));
        check({tag, "_ready"}, 64'(ready), 64'(m.active && !start_i));
        check({tag, "_done"},  64'(done),  64'(m.done));
        check({tag, "_pass"},  64'(pass),  64'(m.pass));
        check({tag, "_fail"},  64'(fail),  64'(m.fail));
        check({tag, "_sig"},   sig,        m.sig);
        check({tag, "_cnt"},   64'(cnt),   64'(m.cnt));
    endtask

    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            cmp_model("a", m_a, start_a, busy_a, if_a.in_ready, done_a, pass_a, fail_a,
                      64'(sig_a), int'(cnt_a));
            cmp_model("b", m_b, start_b, busy_b, if_b.in_ready, done_b, pass_b, fail_b,
                      sig_b, int'(cnt_b));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d);
        if_a.in_valid  = 1'b1;
        if_a.in_result = d;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (if_a.in_ready) begin
                @(negedge clk);
                if_a.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_a_timeout: in_ready never high, required within 50 cycles");
        if_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d);
        if_b.in_valid  = 1'b1;
        if_b.in_result = d;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (if_b.in_ready) begin
                @(negedge clk);
                if_b.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_b_timeout: in_ready never high, required within 50 cycles");
        if_b.in_valid = 1'b0;
    endtask

    task automatic settle();
        #3;
    endtask

    // Full default-config run from the seeded stream; flip_idx<0 means no corruption.
    logic [63:0] gold_s [99];

    task automatic run_gold_b(input int flip_idx);
        logic [63:0] d;
        pulse_start_b();
        for (int i = 0; i < 99; i++) begin
            d = gold_s[i];
            if (i == flip_idx) d = d ^ (64'd1 << $urandom_range(0, 63));
            send_b(d);
        end
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] t1_exp [5];

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] x;
        if_a.in_valid = 1'b0; if_a.in_result = '0;
        if_b.in_valid = 1'b0; if_b.in_result = '0;
        t1_exp = '{8'd0, 8'd0, 8'd1, 8'd3, 8'd7};
        x = CRC_SEED;
        for (int i = 0; i < 99; i++) begin
            x = xs_next(x);
            gold_s[i] = x;
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        settle();
        check("reset_state_a", 64'(st_a), 64'(S_IDLE));
        check("reset_sig_b", sig_b, 64'd0);
        check("reset_flags_b", {61'd0, done_b, pass_b, fail_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: 0,0,1,0,0 back-to-back on the small config
        pulse_start_a();
        for (int k = 0; k < 5; k++) begin
            send_a((k == 2) ? 8'd1 : 8'd0);
            settle();
            check("t1_sig", 64'(sig_a), 64'(t1_exp[k]));
            check("t1_cnt", 64'(cnt_a), 64'(k + 1));
        end
        check("t1_done_not_yet", 64'(done_a), 64'd0);
        @(negedge clk); settle();
        check("t1_done", 64'(done_a), 64'd1);
        check("t1_pass", 64'(pass_a), 64'd1);
        check("t1_fail", 64'(fail_a), 64'd0);

        // Test 3: same data with 1-3 idle cycles between samples
        pulse_start_a();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            send_a((k == 2) ? 8'd1 : 8'd0);
        end
        repeat (2) @(negedge clk); settle();
        check("t3_sig", 64'(sig_a), 64'd7);
        check("t3_pass", 64'(pass_a), 64'd1);

        // Random small runs, one of them restarted mid-run with a sample offered
        for (int r = 0; r < 4; r++) begin
            pulse_start_a();
            for (int k = 0; k < 5; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (r == 2 && k == 3) begin
                    if_a.in_valid = 1'b1;
                    if_a.in_result = 8'($urandom);
                    pulse_start_a();
                    if_a.in_valid = 1'b0;
                    settle();
                    check("rand_restart_cnt", 64'(cnt_a), 64'd0);
                end
                send_a(8'($urandom));
            end
            repeat (3) @(negedge clk);
        end

        // Test 2: ones during warmup, zeros after
        pulse_start_b();
        for (int i = 0; i < 10; i++) send_b({64{1'b1}});
        settle();
        check("t2_sig_at_accum", sig_b, 64'd0);
        check("t2_state_accum", 64'(st_b), 64'(S_ACCUM));
        for (int i = 10; i < 99; i++) send_b(64'd0);
        repeat (2) @(negedge clk); settle();
        check("t2_sig_final", sig_b, 64'd0);
        check("t2_fail", 64'(fail_b), 64'd1);
        check("t2_pass", 64'(pass_b), 64'd0);

        // Test 4: restart mid-accumulate, sample offered in the start cycle
        pulse_start_b();
        for (int i = 0; i < 12; i++) send_b({$urandom, $urandom});
        if_b.in_valid = 1'b1;
        if_b.in_result = {$urandom, $urandom};
        pulse_start_b();
        if_b.in_valid = 1'b0;
        settle();
        check("t4_cnt", 64'(cnt_b), 64'd0);
        check("t4_sig", sig_b, 64'd0);
        check("t4_state", 64'(st_b), 64'(S_WARMUP));
        for (int i = 0; i < 99; i++) send_b(gold_s[i]);
        repeat (2) @(negedge clk); settle();
        check("t4_rerun_pass", 64'(pass_b), 64'd1);

        // Test 5: reset pulse mid-run, then samples without start
        pulse_start_b();
        for (int i = 0; i < 20; i++) send_b({$urandom, $urandom});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("t5_state", 64'(st_b), 64'(S_IDLE));
        check("t5_outputs", {sig_b[56:0], busy_b, done_b, pass_b, fail_b, cnt_b[2:0]}, 64'd0);
        if_b.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        if_b.in_valid = 1'b0;
        settle();
        check("t5_cnt_ignored", 64'(cnt_b), 64'd0);

        // Test 6: seeded stream vs golden; corrupt accumulate sample; corrupt warmup sample
        run_gold_b(-1);
        settle();
        check("t6_pass", 64'(pass_b), 64'd1);
        check("t6_sig", sig_b, GOLD_B);
        run_gold_b(50);
        settle();
        check("t6_flip50_fail", 64'(fail_b), 64'd1);
        run_gold_b(5);
        settle();
        check("t6_flip5_pass", 64'(pass_b), 64'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required end before 400000");
        $fatal(1, "watchdog expired");
    end
endmodule
